// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sequencing a shared 4:1 data mux among four requesters.
// The owner keeps the grant up to MAX_HOLD cycles, then the grant rotates if anyone else is waiting.
module rr_mux4_arbiter #(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   in_data,
    output logic [3:0]            gnt,
    output logic [1:0]            sel,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    output logic [7:0]            hold_cnt
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_GRANT   = 1'b1;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [0:0] r_state;
    logic [0:0] w_stateNext;
    logic [3:0] r_gnt;
    logic [3:0] w_gntNext;
    logic [1:0] r_sel;
    logic [1:0] w_selNext;
    logic [1:0] r_ptr;
    logic [1:0] w_ptrNext;
    logic [7:0] r_hold;
    logic [7:0] w_holdNext;

    logic [1:0] w_winner;
    logic       w_found;
    logic       w_anyReq;
    logic       w_ownerReq;
    logic       w_othersReq;

    // Search starts just after the last owner, so the last owner is considered last.
    always_comb begin
        w_winner = r_ptr;
        w_found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!w_found && req[r_ptr + 2'(k)]) begin
                w_winner = r_ptr + 2'(k);
                w_found  = 1'b1;
            end
        end
    end

    assign w_anyReq    = |req;
    assign w_ownerReq  = req[r_sel];
    assign w_othersReq = |(req & ~r_gnt);

    always_comb begin
        w_stateNext = r_state;
        w_gntNext   = r_gnt;
        w_selNext   = r_sel;
        w_ptrNext   = r_ptr;
        w_holdNext  = r_hold;

        case (r_state)
            S_IDLE: begin
                if (w_anyReq) begin
                    w_stateNext = S_GRANT;
                    w_gntNext   = 4'b0001 << w_winner;
                    w_selNext   = w_winner;
                    w_ptrNext   = w_winner;
                    w_holdNext  = 8'd0;
                end
            end
            S_GRANT: begin
                if (!w_ownerReq) begin
                    w_holdNext = 8'd0;
                    if (w_anyReq) begin
                        w_gntNext = 4'b0001 << w_winner;
                        w_selNext = w_winner;
                        w_ptrNext = w_winner;
                    end else begin
                        w_stateNext = S_IDLE;
                        w_gntNext   = 4'b0000;
                    end
                end else if (r_hold == HOLD_LAST) begin
                    // Owner sits last in the search order, so any other requester wins here.
                    w_holdNext = 8'd0;
                    if (w_othersReq) begin
                        w_gntNext = 4'b0001 << w_winner;
                        w_selNext = w_winner;
                        w_ptrNext = w_winner;
                    end
                end else begin
                    w_holdNext = r_hold + 8'd1;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
                w_gntNext   = 4'b0000;
                w_holdNext  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'd0;
            r_ptr   <= 2'd3;
            r_hold  <= 8'd0;
        end else begin
            r_state <= w_stateNext;
            r_gnt   <= w_gntNext;
            r_sel   <= w_selNext;
            r_ptr   <= w_ptrNext;
            r_hold  <= w_holdNext;
        end
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign hold_cnt  = r_hold;
    assign out_valid = |r_gnt;
    assign out_data  = out_valid ? in_data[r_sel*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Bench for rr_mux4_arbiter: directed vector table for the corner cases, then
// randomized traffic checked against a round-robin model built on plain integers.
module tb_rr_mux4_arbiter;

    localparam int DATA_W   = 8;
    localparam int MAX_HOLD = 8;

    logic                clk;
    logic                reset;
    logic [3:0]          req;
    logic [4*DATA_W-1:0] in_data;
    logic [3:0]          gnt;
    logic [1:0]          sel;
    logic [DATA_W-1:0]   out_data;
    logic                out_valid;
    logic [7:0]          hold_cnt;

    int vectorCount;
    int missCount;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic [7:0] hold;
    } vecT;

    vecT vecs[$];

    logic [7:0] fixedWords [4];

    int mOwner;
    int mPtr;
    int mHold;
    int mSel;

    rr_mux4_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .in_data   (in_data),
        .gnt       (gnt),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .hold_cnt  (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic r, input logic [3:0] q, input logic [3:0] g,
                          input int s, input int h);
        vecT v;
        v.rst  = r;
        v.req  = q;
        v.gnt  = g;
        v.sel  = 2'(s);
        v.hold = 8'(h);
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] q, input logic [4*DATA_W-1:0] d);
        reset   = r;
        req     = q;
        in_data = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [3:0] eGnt, input logic [1:0] eSel,
                               input logic [7:0] eHold, input logic [7:0] eData);
        logic eValid;
        eValid = (eGnt != 4'b0000);
        vectorCount++;
        if ({gnt, sel, hold_cnt, out_valid, out_data} !== {eGnt, eSel, eHold, eValid, eData}) begin
            missCount++;
            $display("[TB] FAIL %s: got gnt=%b sel=%0d hold=%0d valid=%b data=%h, want gnt=%b sel=%0d hold=%0d valid=%b data=%h",
                     name, gnt, sel, hold_cnt, out_valid, out_data, eGnt, eSel, eHold, eValid, eData);
        end
    endtask

    function automatic int pickWinner(input int ptr, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic modelStep(input logic r, input logic [3:0] q);
        int w;
        if (r) begin
            mOwner = -1; mPtr = 3; mHold = 0; mSel = 0;
        end else if (mOwner < 0) begin
            if (q != 4'b0000) begin
                w = pickWinner(mPtr, q);
                mOwner = w; mPtr = w; mSel = w; mHold = 0;
            end
        end else if (!q[mOwner]) begin
            mHold = 0;
            if (q != 4'b0000) begin
                w = pickWinner(mPtr, q);
                mOwner = w; mPtr = w; mSel = w;
            end else begin
                mOwner = -1;
            end
        end else if (mHold == MAX_HOLD - 1) begin
            mHold = 0;
            w = pickWinner(mPtr, q);
            mOwner = w; mPtr = w; mSel = w;
        end else begin
            mHold = mHold + 1;
        end
    endtask

    initial begin
        logic [4*DATA_W-1:0] fixedData;
        logic [4*DATA_W-1:0] rndData;
        logic [3:0]          rndReq;
        logic                rndRst;
        logic [3:0]          eGnt;
        logic [7:0]          eData;

        vectorCount = 0;
        missCount   = 0;
        fixedWords[0] = 8'hA1; fixedWords[1] = 8'hB2;
        fixedWords[2] = 8'hC3; fixedWords[3] = 8'hD4;
        fixedData = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        reset   = 1'b1;
        req     = 4'b1111;
        in_data = fixedData;

        // Reset with all requesting, then the full fairness rotation 0,1,2,3,0
        addVec(1, 4'b1111, 4'b0000, 0, 0);
        addVec(1, 4'b1111, 4'b0000, 0, 0);
        for (int s = 0; s < 40; s++) addVec(0, 4'b1111, 4'b0001 << ((s / 8) % 4), (s / 8) % 4, s % 8);

        // Release from requester 2 hands straight to requester 0
        addVec(1, 4'b0000, 4'b0000, 0, 0);
        addVec(0, 4'b0100, 4'b0100, 2, 0);
        addVec(0, 4'b0101, 4'b0100, 2, 1);
        addVec(0, 4'b0001, 4'b0001, 0, 0);

        // Sole requester keeps the grant across timeouts
        addVec(1, 4'b0000, 4'b0000, 0, 0);
        for (int k = 0; k < 20; k++) addVec(0, 4'b0100, 4'b0100, 2, k % 8);

        // Short pulse then idle with sel held
        addVec(1, 4'b0000, 4'b0000, 0, 0);
        for (int k = 0; k < 3; k++) addVec(0, 4'b0010, 4'b0010, 1, k);
        addVec(0, 4'b0000, 4'b0000, 1, 0);
        addVec(0, 4'b0000, 4'b0000, 1, 0);

        // Reset in the middle of a grant
        addVec(1, 4'b0000, 4'b0000, 0, 0);
        for (int k = 0; k < 6; k++) addVec(0, 4'b1000, 4'b1000, 3, k);
        addVec(1, 4'b1010, 4'b0000, 0, 0);
        addVec(0, 4'b1010, 4'b0010, 1, 0);

        // Owner drop on its timeout cycle counts as a release
        for (int k = 1; k < 8; k++) addVec(0, 4'b1010, 4'b0010, 1, k);
        addVec(0, 4'b1000, 4'b1000, 3, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].req, fixedData);
            eData = (vecs[i].gnt != 4'b0000) ? fixedWords[vecs[i].sel] : 8'h00;
            checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].hold, eData);
        end

        rndReq = 4'b0000;
        for (int i = 0; i < 800; i++) begin
            rndRst = (i == 0) || ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) rndReq = 4'($urandom);
            rndData = {$urandom};
            applyStimulus(rndRst, rndReq, rndData);
            modelStep(rndRst, rndReq);
            eGnt  = (mOwner < 0) ? 4'b0000 : (4'b0001 << mOwner);
            eData = (mOwner < 0) ? 8'h00 : rndData[mOwner*DATA_W +: DATA_W];
            checkOutput($sformatf("rnd%0d", i), eGnt, 2'(mSel), 8'(mHold), eData);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
